// File: rtl/mips_regfile_write_arbiter.sv
// Write-port sequencer for the MIPS register file: after reset it zeroes r1..r31,
// then it grants the port round-robin between pipeline (A) and multi-cycle (B) writeback.
module mips_regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] DataIn,
  output logic                  init_done
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clear_ptr;
  logic                  last_grant;
  logic                  a_xfer, b_xfer;
  wr_req_t               sel;

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state == ST_RUN) begin
      a_ready = a_valid && (!b_valid || last_grant == GNT_B);
      b_ready = b_valid && (!a_valid || last_grant == GNT_A);
    end
  end

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  always_comb begin
    sel = '{addr: b_addr, data: b_data};
    if (a_xfer) sel = '{addr: a_addr, data: a_data};
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state        <= ST_CLEAR;
      clear_ptr    <= ADDR_WIDTH'(1);
      last_grant   <= GNT_B;
      init_done    <= 1'b0;
      RegWrite     <= 1'b0;
      WriteAddress <= '0;
      DataIn       <= '0;
    end else if (state == ST_CLEAR) begin
      RegWrite     <= 1'b1;
      WriteAddress <= clear_ptr;
      DataIn       <= '0;
      clear_ptr    <= clear_ptr + ADDR_WIDTH'(1);
      if (clear_ptr == LAST_REG) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end else if (a_xfer || b_xfer) begin
      // r0 is hardwired zero: the handshake completes but the write is dropped.
      RegWrite     <= (sel.addr != '0);
      WriteAddress <= sel.addr;
      DataIn       <= sel.data;
      last_grant   <= a_xfer ? GNT_A : GNT_B;
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
// Directed bench for mips_regfile_write_arbiter: clear sequence, table of
// arbitration vectors, and reset-abort sequences.
module tb_mips_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        RegWrite;
  logic [4:0]  WriteAddress;
  logic [31:0] DataIn;
  logic        init_done;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  mips_regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .CLK(CLK), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .RegWrite(RegWrite), .WriteAddress(WriteAddress), .DataIn(DataIn),
    .init_done(init_done)
  );

  typedef struct {
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        bv; logic [4:0] ba; logic [31:0] bd;
    logic        ear, ebr, ewe; logic [4:0] ewa; logic [31:0] ewd;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " RegWrite"}, 32'(RegWrite), 0);
    chk({tag, " WriteAddress"}, 32'(WriteAddress), 0);
    chk({tag, " DataIn"}, DataIn, 0);
    chk({tag, " init_done"}, 32'(init_done), 0);
    chk({tag, " a_ready"}, 32'(a_ready), 0);
    chk({tag, " b_ready"}, 32'(b_ready), 0);
  endtask

  // Walk n clear edges after reset release; A is held valid to prove no early ready.
  task automatic do_clear(input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("clr%0d RegWrite", k), 32'(RegWrite), 1);
      chk($sformatf("clr%0d WriteAddress", k), 32'(WriteAddress), 32'(k));
      chk($sformatf("clr%0d DataIn", k), DataIn, 0);
      chk($sformatf("clr%0d init_done", k), 32'(init_done), (k == 31) ? 1 : 0);
      chk($sformatf("clr%0d a_ready", k), 32'(a_ready), (k == 31) ? 1 : 0);
      chk($sformatf("clr%0d b_ready", k), 32'(b_ready), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //            av aa  ad            bv ba  bd            ar br we wa  wd
    tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,            1, 0, 1, 5,  32'hDEADBEEF};
    tbl[1]  = '{0, 0,  0,            0, 0,  0,            0, 0, 0, 5,  32'hDEADBEEF};
    tbl[2]  = '{0, 0,  0,            1, 0,  32'hFFFFFFFF, 0, 1, 0, 0,  32'hFFFFFFFF};
    tbl[3]  = '{1, 3,  32'h11,       1, 4,  32'h22,       1, 0, 1, 3,  32'h11};
    tbl[4]  = '{1, 3,  32'h11,       1, 4,  32'h22,       0, 1, 1, 4,  32'h22};
    tbl[5]  = '{1, 3,  32'h11,       1, 4,  32'h22,       1, 0, 1, 3,  32'h11};
    tbl[6]  = '{1, 3,  32'h11,       1, 4,  32'h22,       0, 1, 1, 4,  32'h22};
    tbl[7]  = '{1, 9,  32'h99,       1, 9,  32'hAA,       1, 0, 1, 9,  32'h99};
    tbl[8]  = '{0, 0,  0,            1, 9,  32'hAA,       0, 1, 1, 9,  32'hAA};
    tbl[9]  = '{1, 1,  32'h1,        0, 0,  0,            1, 0, 1, 1,  32'h1};
    tbl[10] = '{1, 7,  32'h77,       1, 13, 32'hDD,       0, 1, 1, 13, 32'hDD};
    tbl[11] = '{1, 7,  32'h77,       0, 0,  0,            1, 0, 1, 7,  32'h77};
    tbl[12] = '{0, 0,  0,            0, 0,  0,            0, 0, 0, 7,  32'h77};
    tbl[13] = '{1, 0,  0,            1, 31, 32'h5A5A,     0, 1, 1, 31, 32'h5A5A};
    tbl[14] = '{1, 0,  32'h1234,     0, 0,  0,            1, 0, 0, 0,  32'h1234};

    reset = 1'b0;
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h0BAD;
    b_valid = 1'b0; b_addr = '0;   b_data = '0;
    repeat (3) @(negedge CLK);
    chk_reset_vals("in_reset");
    reset = 1'b1;
    do_clear(31);
    a_valid = 1'b0;

    foreach (tbl[i]) begin
      @(negedge CLK);
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      #1;
      chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(tbl[i].ear));
      chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(tbl[i].ebr));
      @(posedge CLK); #1;
      chk($sformatf("v%0d RegWrite", i), 32'(RegWrite), 32'(tbl[i].ewe));
      chk($sformatf("v%0d WriteAddress", i), 32'(WriteAddress), 32'(tbl[i].ewa));
      chk($sformatf("v%0d DataIn", i), DataIn, tbl[i].ewd);
    end

    // Reset in the middle of a RUN write cycle clears outputs without waiting for an edge.
    @(negedge CLK);
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66; b_valid = 1'b0;
    @(posedge CLK); #1;
    chk("run_pre RegWrite", 32'(RegWrite), 1);
    chk("run_pre WriteAddress", 32'(WriteAddress), 6);
    #2 reset = 1'b0;
    #1 chk_reset_vals("run_abort");

    @(negedge CLK);
    reset = 1'b1;
    do_clear(10);
    reset = 1'b0;
    #1;
    chk("clr_abort RegWrite", 32'(RegWrite), 0);
    chk("clr_abort WriteAddress", 32'(WriteAddress), 0);
    chk("clr_abort init_done", 32'(init_done), 0);
    @(negedge CLK);
    reset = 1'b1;
    do_clear(31);
    a_valid = 1'b0;
    @(posedge CLK); #1;
    chk("post_clear RegWrite", 32'(RegWrite), 0);
    chk("post_clear init_done", 32'(init_done), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
